// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage definitions: func codes for the mul/div unit and small helpers.
// Multiply classification depends on MULDIV_FASTMUL_EN.
package ex_muldiv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned FUNC_W = 6;
    localparam int unsigned CNT_W  = 5;

    localparam logic [FUNC_W-1:0] FUNC_MULT  = 6'b011000;
    localparam logic [FUNC_W-1:0] FUNC_MULTU = 6'b011001;
    localparam logic [FUNC_W-1:0] FUNC_DIV   = 6'b011010;
    localparam logic [FUNC_W-1:0] FUNC_DIVU  = 6'b011011;
    localparam logic [FUNC_W-1:0] FUNC_MTHI  = 6'b010001;
    localparam logic [FUNC_W-1:0] FUNC_MTLO  = 6'b010011;

    // Operation context latched at accept and consumed by the sign-fix state
    typedef struct packed {
        logic is_div;
        logic res_neg;
        logic rem_neg;
        logic b_zero;
    } op_info_t;

    // Ops that take the iterative path and therefore stall the pipeline
    function automatic logic is_multi(input logic [FUNC_W-1:0] f);
`ifdef MULDIV_FASTMUL_EN
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
`else
        return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
`endif
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic              start;
    logic [FUNC_W-1:0] func;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              flush;
    logic              stall;
    logic              done;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    modport master (output start, func, a, b, flush, input stall, done, hi, lo);
    modport slave  (input start, func, a, b, flush, output stall, done, hi, lo);
endinterface

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module ex_muldiv_div_step
    import ex_muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic [XLEN:0] trial;

    // The running remainder is always below the divisor, so the difference fits in XLEN bits
    always_comb begin
        trial = {rem_in, quo_in[XLEN-1]};
        if (trial >= {1'b0, divisor}) begin
            rem_out = XLEN'(trial - {1'b0, divisor});
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiply.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opd;      // mul: multiplicand magnitude; div: divisor magnitude
    op_info_t          op;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;

    logic              accept_c;
    logic              multi_c;
    logic              signed_c;
    logic              is_div_c;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;
    logic [2*XLEN-1:0] fix_mul;
    logic [XLEN-1:0]   fix_rem;
    logic [XLEN-1:0]   fix_quo;

    assign multi_c  = is_multi(bus.func);
    assign signed_c = (bus.func == FUNC_MULT) || (bus.func == FUNC_DIV);
    assign is_div_c = (bus.func == FUNC_DIV) || (bus.func == FUNC_DIVU);
    assign accept_c = (state == IDLE) && bus.start && !done_q && !bus.flush;

    assign bus.stall = (state != IDLE) || (bus.start && multi_c && !done_q);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : (XLEN+1)'(0));
    assign fix_mul = op.res_neg ? (2*XLEN)'(-acc) : acc;
    assign fix_quo = op.res_neg ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    assign fix_rem = op.rem_neg ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

    ex_muldiv_div_step u_div_step (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (opd),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

`ifdef MULDIV_FASTMUL_EN
    logic              is_mul_c;
    logic [2*XLEN-1:0] fast_prod;

    assign is_mul_c = (bus.func == FUNC_MULT) || (bus.func == FUNC_MULTU);

    // Low 64 bits of a 64x64 product of the extended operands give the signed or unsigned result
    always_comb begin
        if (signed_c)
            fast_prod = {{XLEN{bus.a[XLEN-1]}}, bus.a} * {{XLEN{bus.b[XLEN-1]}}, bus.b};
        else
            fast_prod = {{XLEN{1'b0}}, bus.a} * {{XLEN{1'b0}}, bus.b};
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            op     <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (accept_c) begin
                        if (bus.func == FUNC_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.func == FUNC_MTLO) begin
                            lo_q <= bus.a;
`ifdef MULDIV_FASTMUL_EN
                        end else if (is_mul_c) begin
                            {hi_q, lo_q} <= fast_prod;
                            done_q       <= 1'b1;
`endif
                        end else if (multi_c) begin
                            state <= RUN;
                            cnt   <= '0;
                            acc   <= {{XLEN{1'b0}}, mag(is_div_c ? bus.a : bus.b, signed_c)};
                            opd   <= mag(is_div_c ? bus.b : bus.a, signed_c);
                            op    <= '{is_div:  is_div_c,
                                       res_neg: signed_c && (bus.a[XLEN-1] ^ bus.b[XLEN-1]),
                                       rem_neg: signed_c && bus.a[XLEN-1],
                                       b_zero:  (bus.b == '0)};
                        end
                    end
                    RUN: begin
                        acc <= op.is_div ? {div_rem, div_quo} : {mul_sum, acc[XLEN-1:1]};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN-1))
                            state <= FIX;
                    end
                    FIX: begin
                        if (!op.is_div) begin
                            {hi_q, lo_q} <= fix_mul;
                        end else if (!op.b_zero) begin
                            hi_q <= fix_rem;
                            lo_q <= fix_quo;
                        end
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO registers. It sits in the EX stage beside the ALU and takes the same A/B operands and func code. It executes MULT/MULTU/DIV/DIVU iteratively, and MTHI/MTLO in one cycle. It stalls the pipeline while busy and supplies hi/lo to MFHI/MFLO forwarding.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid instruction for this unit; held high by upstream while stall=1.
- func  in  6  function code from the shared header: MULT, MULTU, DIV, DIVU, MTHI, MTLO. Any other value is ignored.
- A  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- B  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception/ERET flush; aborts any operation in flight.
- stall  out  1  combinational; freeze IF/ID/EX this cycle.
- done  out  1  registered one-cycle pulse: result is in hi/lo this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- Multi-cycle op: func is MULT/MULTU/DIV/DIVU (MULT/MULTU only when fast multiply is not configured).
- Accept condition: state==IDLE && start && !done && !flush.
- IDLE → RUN on accept of a multi-cycle op. Latch |A| and |B| (signed ops) or A and B (unsigned ops). Latch the result sign, remainder sign, op kind, and B==0. Counter cnt=0.
- RUN does one iteration per cycle with cnt 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: radix-2 restoring division producing a 32-bit quotient and remainder.
- RUN → FIX when cnt==31.
- FIX applies two's-complement sign correction:
  - MULT: negate the 64-bit product if signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- FIX writes {hi,lo} (HI=product[63:32] or remainder; LO=product[31:0] or quotient). It sets done=1 and goes to IDLE.
- Divisor zero: runs full latency; hi/lo are unchanged; done still pulses.
- Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no exception).
- MTHI/MTLO accepted: write hi or lo from A at that edge. No done pulse, no stall.
- stall = (state!=IDLE) || (start && multi-cycle func && state==IDLE && !done).
- flush in any state: next edge returns to IDLE, done=0, hi/lo unchanged; a same-cycle start is not accepted.
- start while not IDLE: ignored (the stall holds it).

## Timing
- Reset values: state=IDLE, cnt=0, hi=0, lo=0, done=0. stall therefore follows only start/func.
- Iterative latency: accept at edge E0; RUN covers edges E1..E32; FIX updates hi/lo at E33; done=1 in the cycle after E33, and stall=0 in that cycle.
- Exactly 33 stall cycles per iterative op.
- MTHI/MTLO: visible the cycle after the accept edge.
- The done cycle blocks re-accept of the still-held instruction. The pipeline advances in that cycle.
- Reset mid-RUN: immediate return to reset values.

## Configuration
- MULDIV_FASTMUL_EN defined:
  - MULT/MULTU use a single-cycle combinational signed/unsigned 64-bit product.
  - {hi,lo} are written at the accept edge, done pulses the next cycle, and stall is never raised for multiply.
  - Divide is unchanged.
- MULDIV_FASTMUL_EN undefined: multiply uses the 33-cycle iterative path above.

## Structure
- Func-code constants (MULT 6'b011000, MULTU 6'b011001, DIV 6'b011010, DIVU 6'b011011, MTHI 6'b010001, MTLO 6'b010011) belong in the shared header alongside the ALU codes.
- State encodings are local.
- One sub-module is natural: div_step, a combinational single restoring-division iteration (remainder, quotient in → remainder, quotient out).

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 stall cycles, done; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFE (-2), B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 → LO=3, HI=1.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU B=0 with prior HI=0x11, LO=0x22 → unchanged, done pulses at cycle 34.
- Start DIVU, assert flush at cycle 10 → stall drops next cycle, no done, hi/lo unchanged. MTHI A=0x1234 next cycle → HI=0x1234.
- Assert reset mid-RUN → hi=lo=0, stall follows start only. With MULDIV_FASTMUL_EN, MULTU 3×5 → LO=15 next cycle, stall never high.
